// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator: owns the fetch PC, looks up a direct-mapped
// BTB on the current PC, combines it with the bimodal predictor's hit/taken,
// and picks the next PC. Execute-stage mispredicts override the choice and
// execute-stage resolutions train the BTB.
// Optional feature macro: FETCH_STATS_EN adds saturating redirect and
// predicted-taken fetch counters as extra output ports.

`ifndef XLEN
`define XLEN 32
`endif

module fetch_pc_gen #(
  parameter int               BTB_ENTRIES = 16,
  parameter logic [`XLEN-1:0] RESET_PC    = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             if_ready,
  input  logic             bp_predict_taken,
  input  logic             bp_hit,
  input  logic             ex_resolve_valid,
  input  logic [`XLEN-1:0] ex_pc,
  input  logic             ex_taken,
  input  logic [`XLEN-1:0] ex_target,
  input  logic             ex_mispredict,
  input  logic [`XLEN-1:0] ex_redirect_pc,
  output logic [`XLEN-1:0] if_pc,
  output logic             if_valid,
  output logic             if_pred_taken,
  output logic [`XLEN-1:0] if_pred_target
`ifdef FETCH_STATS_EN
  ,
  output logic [`XLEN-1:0] stat_redirects,
  output logic [`XLEN-1:0] stat_pred_taken
`endif
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = `XLEN - IDX - 2;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [`XLEN-1:0] pc_q, pc_d;

  // BTB storage: valid bits are reset, tag and target are only meaningful when valid
  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
  logic [`XLEN-3:0]       btb_target [BTB_ENTRIES];

  logic [IDX-1:0]   rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             btb_hit;
  logic             btb_wr_en;
  logic [`XLEN-1:0] pc_plus4;
  logic [`XLEN-1:0] redirect_pc;

  // Address low bits are architecturally zero and are dropped on every path
  logic unused_low_bits;
  assign unused_low_bits = ^{ex_pc[1:0], ex_target[1:0], ex_redirect_pc[1:0]};

  assign rd_idx    = pc_q[IDX+1:2];
  assign rd_tag    = pc_q[`XLEN-1:IDX+2];
  assign wr_idx    = ex_pc[IDX+1:2];
  assign wr_tag    = ex_pc[`XLEN-1:IDX+2];
  assign btb_wr_en = ex_resolve_valid && ex_taken;

  assign btb_hit     = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
  assign pc_plus4    = pc_q + `XLEN'(4);
  assign redirect_pc = {ex_redirect_pc[`XLEN-1:2], 2'b00};

  assign if_pc          = pc_q;
  assign if_valid       = (state_q == RUN);
  assign if_pred_taken  = if_valid && bp_hit && bp_predict_taken && btb_hit;
  assign if_pred_target = if_pred_taken ? {btb_target[rd_idx], 2'b00} : pc_plus4;

  // Next-state and next-PC: mispredict wins, then an accepted RUN fetch, else hold
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      FLUSH:   state_d = RUN;
      default: state_d = BOOT;
    endcase
    if (ex_mispredict) begin
      state_d = FLUSH;
      pc_d    = redirect_pc;
    end else if ((state_q == RUN) && if_ready) begin
      pc_d = if_pred_target;
    end
  end

  // PC and FSM state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // BTB valid bits: set on a taken resolution, cleared only by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btb_valid <= '0;
    end else if (btb_wr_en) begin
      btb_valid[wr_idx] <= 1'b1;
    end
  end

  // BTB tag/target write; reads this cycle still see the old entry
  always_ff @(posedge clock) begin
    if (btb_wr_en) begin
      btb_tag[wr_idx]    <= wr_tag;
      btb_target[wr_idx] <= ex_target[`XLEN-1:2];
    end
  end

`ifdef FETCH_STATS_EN
  // Saturating counters for redirects and predicted-taken accepted fetches
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_redirects  <= '0;
      stat_pred_taken <= '0;
    end else begin
      if (ex_mispredict && (stat_redirects != '1)) begin
        stat_redirects <= stat_redirects + `XLEN'(1);
      end
      if (if_valid && if_ready && if_pred_taken && (stat_pred_taken != '1)) begin
        stat_pred_taken <= stat_pred_taken + `XLEN'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed steps from the test plan
// followed by randomized traffic, all compared against a behavioural model.

`ifndef XLEN
`define XLEN 32
`endif

module tb_fetch_pc_gen;

  localparam int BTB = 16;

  logic             clock;
  logic             reset;
  logic             if_ready;
  logic             bp_predict_taken;
  logic             bp_hit;
  logic             ex_resolve_valid;
  logic [`XLEN-1:0] ex_pc;
  logic             ex_taken;
  logic [`XLEN-1:0] ex_target;
  logic             ex_mispredict;
  logic [`XLEN-1:0] ex_redirect_pc;
  logic [`XLEN-1:0] if_pc;
  logic             if_valid;
  logic             if_pred_taken;
  logic [`XLEN-1:0] if_pred_target;
`ifdef FETCH_STATS_EN
  logic [`XLEN-1:0] stat_redirects;
  logic [`XLEN-1:0] stat_pred_taken;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_pc_gen #(.BTB_ENTRIES(BTB), .RESET_PC('0)) dut (
    .clock            (clock),
    .reset            (reset),
    .if_ready         (if_ready),
    .bp_predict_taken (bp_predict_taken),
    .bp_hit           (bp_hit),
    .ex_resolve_valid (ex_resolve_valid),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_mispredict    (ex_mispredict),
    .ex_redirect_pc   (ex_redirect_pc),
    .if_pc            (if_pc),
    .if_valid         (if_valid),
    .if_pred_taken    (if_pred_taken),
    .if_pred_target   (if_pred_target)
`ifdef FETCH_STATS_EN
    ,
    .stat_redirects   (stat_redirects),
    .stat_pred_taken  (stat_pred_taken)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: fetch phase, PC, and BTB as "which branch word owns this slot"
  typedef enum {M_BOOT, M_RUN, M_FLUSH} phase_t;
  phase_t           mPhase;
  logic [`XLEN-1:0] mPc;
  logic [`XLEN-1:0] mBtbWord [int];
  logic [`XLEN-1:0] mBtbTgt  [int];

  function automatic int slotOf(input logic [`XLEN-1:0] pc);
    return int'((pc >> 2) % BTB);
  endfunction

  function automatic logic modelHit(input logic [`XLEN-1:0] pc);
    int s = slotOf(pc);
    return mBtbWord.exists(s) && (mBtbWord[s] == (pc >> 2));
  endfunction

  function automatic logic modelPredTaken();
    return (mPhase == M_RUN) && bp_hit && bp_predict_taken && modelHit(mPc);
  endfunction

  function automatic logic [`XLEN-1:0] modelPredTarget();
    if (modelPredTaken()) return mBtbTgt[slotOf(mPc)];
    return mPc + 4;
  endfunction

  task automatic modelReset();
    mPhase = M_BOOT;
    mPc    = '0;
    mBtbWord.delete();
    mBtbTgt.delete();
  endtask

  // Advance the model by one clock edge using the inputs that were present at it
  task automatic modelUpdate();
    logic [`XLEN-1:0] nextFetch;
    nextFetch = modelPredTarget();
    if (ex_resolve_valid && ex_taken) begin
      mBtbWord[slotOf(ex_pc)] = ex_pc >> 2;
      mBtbTgt[slotOf(ex_pc)]  = ex_target & ~`XLEN'(3);
    end
    if (ex_mispredict) begin
      mPc    = ex_redirect_pc & ~`XLEN'(3);
      mPhase = M_FLUSH;
    end else begin
      if (mPhase == M_RUN && if_ready) mPc = nextFetch;
      mPhase = M_RUN;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [`XLEN-1:0] observed,
                             input logic [`XLEN-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".pc"}, if_pc, mPc);
    checkOutput({tag, ".valid"}, `XLEN'(if_valid), `XLEN'(mPhase == M_RUN));
    checkOutput({tag, ".ptaken"}, `XLEN'(if_pred_taken), `XLEN'(modelPredTaken()));
    checkOutput({tag, ".ptarget"}, if_pred_target, modelPredTarget());
  endtask

  task automatic applyStimulus(input logic rdy, input logic hit, input logic tkn,
                               input logic rv, input logic [`XLEN-1:0] epc,
                               input logic etk, input logic [`XLEN-1:0] etgt,
                               input logic mis, input logic [`XLEN-1:0] rpc);
    if_ready         = rdy;
    bp_hit           = hit;
    bp_predict_taken = tkn;
    ex_resolve_valid = rv;
    ex_pc            = epc;
    ex_taken         = etk;
    ex_target        = etgt;
    ex_mispredict    = mis;
    ex_redirect_pc   = rpc;
  endtask

  // Check current outputs, then cross one rising edge and update the model
  task automatic stepCycle(input string tag);
    #1;
    checkModel(tag);
    @(posedge clock);
    #1;
    modelUpdate();
  endtask

  task automatic resetDut(input string tag);
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput({tag, ".pc"}, if_pc, '0);
    checkOutput({tag, ".valid"}, `XLEN'(if_valid), '0);
    checkOutput({tag, ".ptarget"}, if_pred_target, `XLEN'(4));
    repeat (2) @(posedge clock);
    #1;
    checkModel({tag, ".hold"});
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, '0, 0, '0, 0, '0);
    resetDut("reset0");

    // Sequential fetch from reset
    applyStimulus(1, 0, 0, 0, '0, 0, '0, 0, '0);
    stepCycle("boot");
    stepCycle("seq0");
    stepCycle("seq4");
    checkOutput("seq.at8", if_pc, `XLEN'('h8));

    // Stall for three cycles, then resume
    applyStimulus(0, 0, 0, 0, '0, 0, '0, 0, '0);
    repeat (3) stepCycle("stall");
    applyStimulus(1, 0, 0, 0, '0, 0, '0, 0, '0);
    stepCycle("resume");
    checkOutput("resume.atC", if_pc, `XLEN'('hC));

    // Train 0x10 -> 0x40 and take it
    applyStimulus(1, 0, 0, 1, `XLEN'('h10), 1, `XLEN'('h40), 0, '0);
    stepCycle("train10");
    applyStimulus(1, 1, 1, 0, '0, 0, '0, 0, '0);
    #1;
    checkOutput("btb.ptaken", `XLEN'(if_pred_taken), `XLEN'(1));
    checkOutput("btb.ptarget", if_pred_target, `XLEN'('h40));
    stepCycle("take10");
    checkOutput("btb.at40", if_pc, `XLEN'('h40));

    // Back to 0x10 with predictor saying not-taken
    applyStimulus(1, 0, 0, 0, '0, 0, '0, 1, `XLEN'('h10));
    stepCycle("redir10");
    applyStimulus(1, 0, 0, 0, '0, 0, '0, 0, '0);
    stepCycle("flush10");
    applyStimulus(1, 1, 0, 0, '0, 0, '0, 0, '0);
    stepCycle("nt10");
    checkOutput("nt.at14", if_pc, `XLEN'('h14));

    // Alias 0x50 into the same slot; 0x10 now misses on tag
    applyStimulus(1, 0, 0, 1, `XLEN'('h50), 1, `XLEN'('h80), 1, `XLEN'('h10));
    stepCycle("alias50");
    applyStimulus(1, 0, 0, 0, '0, 0, '0, 0, '0);
    stepCycle("flushA");
    applyStimulus(1, 1, 1, 0, '0, 0, '0, 0, '0);
    stepCycle("tagmiss");
    checkOutput("tagmiss.at14", if_pc, `XLEN'('h14));

    // Misaligned redirect while stalled
    applyStimulus(0, 0, 0, 0, '0, 0, '0, 1, `XLEN'('h103));
    stepCycle("redir103");
    applyStimulus(0, 0, 0, 0, '0, 0, '0, 0, '0);
    checkOutput("flush.pc", if_pc, `XLEN'('h100));
    checkOutput("flush.valid", `XLEN'(if_valid), '0);
    stepCycle("flush100");
    checkOutput("run.valid", `XLEN'(if_valid), `XLEN'(1));
    checkOutput("run.pc", if_pc, `XLEN'('h100));

    // Retrain 0x10, redirect to 0x44, then reset mid-cycle
    applyStimulus(1, 0, 0, 1, `XLEN'('h10), 1, `XLEN'('h40), 1, `XLEN'('h44));
    stepCycle("retrain");
    applyStimulus(1, 0, 0, 0, '0, 0, '0, 0, '0);
    stepCycle("flush44");
    checkOutput("pre.at44", if_pc, `XLEN'('h44));
    resetDut("midreset");
    applyStimulus(1, 1, 1, 0, '0, 0, '0, 0, '0);
    repeat (5) stepCycle("postrst");
    checkOutput("postrst.at10", if_pc, `XLEN'('h10));
    checkOutput("postrst.ptaken", `XLEN'(if_pred_taken), '0);

    // Same-slot read and write in one cycle: the read sees the old entry
    applyStimulus(1, 1, 1, 1, `XLEN'('h10), 1, `XLEN'('h80), 0, '0);
    stepCycle("rdwr");
    checkOutput("rdwr.at14", if_pc, `XLEN'('h14));

    // PC+4 wraps around the top of the address space
    applyStimulus(1, 0, 0, 0, '0, 0, '0, 1, '1);
    stepCycle("redirTop");
    applyStimulus(1, 0, 0, 0, '0, 0, '0, 0, '0);
    stepCycle("flushTop");
    stepCycle("wrap");
    checkOutput("wrap.at0", if_pc, '0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) != 0),
                    `XLEN'($urandom_range(0, 'h1FF)), ($urandom_range(0, 3) != 0),
                    `XLEN'($urandom_range(0, 'h1FF)), ($urandom_range(0, 7) == 0),
                    `XLEN'($urandom_range(0, 'h1FF)));
      stepCycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
Fetch-stage next-PC generator. It owns the architectural fetch PC and presents it to the icache and to the bimodal branch predictor. It combines the predictor's taken/hit with its own direct-mapped branch target buffer (BTB) to choose the next PC. Execute-stage mispredict redirects override the choice, and execute-stage branch resolutions train the BTB.

Parameters:
BTB_ENTRIES, 16, number of BTB entries; power of two, minimum 2.
RESET_PC, 0, PC loaded at reset; bits [1:0] must be 0.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
if_ready  input  1  icache/fetch accepts current PC this cycle
bp_predict_taken  input  1  predictor taken output for if_pc
bp_hit  input  1  predictor entry valid for if_pc
ex_resolve_valid  input  1  a branch resolved in execute this cycle
ex_pc  input  `XLEN  PC of the resolved branch
ex_taken  input  1  resolved branch was taken
ex_target  input  `XLEN  resolved taken target
ex_mispredict  input  1  flush fetch and redirect
ex_redirect_pc  input  `XLEN  correct PC after mispredict
if_pc  output  `XLEN  current fetch PC; also drives the predictor if_pc input
if_valid  output  1  if_pc is a real fetch request
if_pred_taken  output  1  fetch at if_pc predicted taken
if_pred_target  output  `XLEN  predicted next PC for this fetch

Behaviour:
- Reset asserted, asynchronous:
  - PC = RESET_PC; state = BOOT.
  - All BTB valid bits = 0.
  - if_valid = 0, if_pred_taken = 0, if_pred_target = RESET_PC+4.
- FSM, 3 states:
  - BOOT: first cycle after reset release; if_valid = 0. Next state RUN; PC unchanged.
  - RUN: if_valid = 1. ex_mispredict -> FLUSH.
  - FLUSH: if_valid = 0 for exactly one cycle. Next state RUN, unless ex_mispredict again, which stays in FLUSH with the newer PC.
- BTB organisation:
  - Direct-mapped; index = pc[IDX+1:2] with IDX = log2(BTB_ENTRIES).
  - Tag = pc[`XLEN-1:IDX+2]. Each entry holds valid, tag and target[`XLEN-1:2].
- BTB read: combinational on if_pc. btb_hit = valid && tag match.
- BTB write: on a clock edge when ex_resolve_valid && ex_taken; writes tag, target and valid = 1.
  - Not-taken resolutions do not modify the BTB.
  - Read and write to the same index in the same cycle: the read returns the old contents; the new entry is visible next cycle.
- Prediction:
  - if_pred_taken = if_valid && bp_hit && bp_predict_taken && btb_hit.
  - if_pred_target = BTB target if if_pred_taken, else if_pc+4.
- Next-PC priority, evaluated on each rising edge:
  1. ex_mispredict: PC <= ex_redirect_pc; state <= FLUSH. Applies in any state except reset, regardless of if_ready.
  2. RUN && if_ready: PC <= if_pred_target.
  3. Otherwise: hold PC.
- Width and alignment rules:
  - Bits [1:0] of ex_redirect_pc and ex_target are forced to 0 before use.
  - PC+4 wraps modulo 2^`XLEN with no error.
- A redirect and a BTB training event in the same cycle both take effect.
- Reset mid-operation: all state returns to reset values immediately, including any pending FLUSH.
- if_pc is driven only from the PC register, so there is no combinational path from the ex_* inputs to if_pc.

Optional Feature:
FETCH_STATS_EN
- Defined: adds two output ports, each `XLEN wide, saturating, cleared by reset:
  - stat_redirects: increments on every ex_mispredict edge.
  - stat_pred_taken: increments on each accepted fetch (if_valid && if_ready) with if_pred_taken = 1.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Reset low, release, if_ready=1, no predictor hits -> cycle 0 if_valid=0 at 0x0; following cycles if_pc=0x0, 0x4, 0x8 with if_valid=1.
- At if_pc=0x8, hold if_ready=0 for 3 cycles -> if_pc stays 0x8, if_valid=1; if_ready=1 -> next if_pc=0xC.
- Resolve ex_pc=0x10, ex_taken=1, ex_target=0x40; later fetch 0x10 with bp_hit=1, bp_predict_taken=1 -> if_pred_taken=1, if_pred_target=0x40, next if_pc=0x40.
- Same BTB state, fetch 0x10 with bp_predict_taken=0, or BTB trained at index match but tag mismatch (ex_pc=0x50) -> if_pred_taken=0, next if_pc=0x14.
- ex_mispredict=1, ex_redirect_pc=0x103, while if_ready=0 -> next cycle if_valid=0 with if_pc=0x100; the cycle after, if_valid=1 with if_pc=0x100.
- Running at if_pc=0x44 with BTB trained, drive reset low mid-cycle -> if_valid=0 and if_pc=0x0 immediately; after release, fetch at 0x10 gives if_pred_taken=0.
